// File: rtl/example_reg_master.sv
// Register-bus initiator: one read/write at a time, acked or timed out; option EXAMPLE_REG_MASTER_UNINIT_CHECK_EN.
// Latency: accept -> rsp_valid = 2 cycles + ack wait (1 cycle for rejected commands).
// Backpressure: cmd_ready only in IDLE; the response is held until rsp_ready.
module example_reg_master #(
    parameter int                  ADDR_WIDTH     = 4,
    parameter int                  DATA_WIDTH     = 32,
    parameter int                  NUM_REGS       = 9,
    parameter int                  TIMEOUT_CYCLES = 16,
    parameter logic [NUM_REGS-1:0] UNRESET_MASK   = 9'b001100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_wr,
    output logic                  bus_rd,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_ack
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RESP} state_t;

    localparam logic [ADDR_WIDTH:0] NUM_REGS_W   = (ADDR_WIDTH+1)'(NUM_REGS);
    localparam logic [7:0]          TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    cmd_fire, in_range, uninit_hit, bus_done, expire;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign in_range = {1'b0, cmd_addr} < NUM_REGS_W;
    assign bus_done = ((state_q == ISSUE) || (state_q == WAIT_ACK)) && bus_ack;
    // An ack in the expiry cycle takes priority over the timeout.
    assign expire   = (state_q == WAIT_ACK) && !bus_ack && (cnt_q == TIMEOUT_LAST);

`ifdef EXAMPLE_REG_MASTER_UNINIT_CHECK_EN
    logic [NUM_REGS-1:0] written_q, written_d;
    assign uninit_hit = in_range && !cmd_write && UNRESET_MASK[cmd_addr] && !written_q[cmd_addr];
`else
    logic unused_mask;
    assign unused_mask = ^UNRESET_MASK;
    assign uninit_hit  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
`ifdef EXAMPLE_REG_MASTER_UNINIT_CHECK_EN
            written_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
`ifdef EXAMPLE_REG_MASTER_UNINIT_CHECK_EN
            written_q <= written_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
`ifdef EXAMPLE_REG_MASTER_UNINIT_CHECK_EN
        written_d = written_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (!in_range || uninit_hit) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = bus_ack ? RESP : WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus_ack || expire) state_d = RESP;
                else                   cnt_d   = cnt_q + 8'd1;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus_done) begin
            rdata_d = write_q ? '0 : bus_rdata;
            err_d   = 1'b0;
`ifdef EXAMPLE_REG_MASTER_UNINIT_CHECK_EN
            if (write_q) written_d[addr_q] = 1'b1;
`endif
        end else if (expire) begin
            rdata_d = '0;
            err_d   = 1'b1;
        end
    end

    // Reset forces every output low in the reset cycle itself, including the strobes.
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_wr    = 1'b0;
        bus_rd    = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: cmd_ready = 1'b1;
                ISSUE: begin
                    bus_addr  = addr_q;
                    bus_wdata = wdata_q;
                    bus_wr    = write_q;
                    bus_rd    = !write_q;
                end
                WAIT_ACK: begin
                    bus_addr  = addr_q;
                    bus_wdata = wdata_q;
                end
                RESP: begin
                    rsp_valid = 1'b1;
                    rsp_rdata = rdata_q;
                    rsp_err   = err_q;
                end
                default: cmd_ready = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_example_reg_master.sv
// Bench for example_reg_master: random commands and responder delays, responses scored against a transaction-level model.
`timescale 1ns/1ps
module tb_example_reg_master;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NR = 9;
    localparam int TO = 16;
    localparam logic [NR-1:0] MASK = 9'b001100000;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] bus_addr;
    logic          bus_wr, bus_rd, bus_ack;
    logic [DW-1:0] bus_wdata, bus_rdata;

    example_reg_master dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nstb;
        logic [3:0]  addr;
        logic        wr;
        int          acc_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          dly_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          hold_mode = 0;
    logic [31:0] model_mem[NR];
    logic [31:0] resp_mem[NR];
`ifdef EXAMPLE_REG_MASTER_UNINIT_CHECK_EN
    logic [NR-1:0] model_bm;
`endif

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Transaction-level outcome: rejected, completed after d cycles, or timed out.
    function automatic exp_t model(input logic wr, input logic [3:0] a, input logic [31:0] wd, input int d);
        exp_t e;
        e.addr = a; e.wr = wr; e.rdata = '0; e.err = 1'b1; e.lat = 1; e.nstb = 0; e.acc_cyc = 0;
        if (int'(a) >= NR) return e;
`ifdef EXAMPLE_REG_MASTER_UNINIT_CHECK_EN
        if (!wr && MASK[a] && !model_bm[a]) return e;
`endif
        e.nstb = 1;
        if (wr) model_mem[a] = wd;
        if (d >= 0 && d <= TO) begin
            e.err = 1'b0;
            e.lat = 2 + d;
            if (!wr) e.rdata = model_mem[a];
`ifdef EXAMPLE_REG_MASTER_UNINIT_CHECK_EN
            if (wr) model_bm[a] = 1'b1;
`endif
        end else begin
            e.lat = 2 + TO;
        end
        return e;
    endfunction

    // Responder: latches writes on the strobe, acks d cycles after it (never when d < 0).
    initial begin
        int          pend;
        logic [3:0]  p_addr;
        logic        p_wr;
        pend = -1; p_addr = '0; p_wr = 1'b0;
        bus_ack = 1'b0; bus_rdata = '0;
        forever begin
            @(negedge clk);
            bus_ack = 1'b0;
            bus_rdata = '0;
            if (reset) begin
                pend = -1;
            end else begin
                if (bus_rd || bus_wr) begin
                    p_addr = bus_addr;
                    p_wr   = bus_wr;
                    if (bus_wr && int'(bus_addr) < NR) resp_mem[bus_addr] = bus_wdata;
                    pend = (dly_q.size() > 0) ? dly_q.pop_front() : -1;
                end else if (pend > 0) begin
                    pend--;
                end
                if (pend == 0) begin
                    bus_ack   = 1'b1;
                    bus_rdata = p_wr ? $urandom : ((int'(p_addr) < NR) ? resp_mem[p_addr] : 32'hDEAD_BEEF);
                    pend      = -1;
                end
            end
        end
    end

    // Monitor: drives rsp_ready, scores every response and the strobes seen for it.
    initial begin
        int          hold, nstb;
        bit          in_rsp;
        logic [31:0] h_rd;
        logic        h_err, s_wr;
        logic [3:0]  s_addr;
        exp_t        e;
        hold = 0; nstb = 0; in_rsp = 0; h_rd = '0; h_err = 1'b0; s_wr = 1'b0; s_addr = '0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_rsp = 0; nstb = 0; rsp_ready = 1'b0;
                continue;
            end
            if (bus_rd || bus_wr) begin
                nstb++;
                s_addr = bus_addr;
                s_wr   = bus_wr;
            end
            if (!rsp_valid) begin
                in_rsp = 0;
                rsp_ready = 1'($urandom_range(0, 1));
                continue;
            end
            chk("cmd_ready_during_rsp", {63'd0, cmd_ready}, 64'd0);
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL rsp_unexpected: actual rsp_valid=1 required 0 (cycle %0d)", cyc);
                rsp_ready = 1'b1;
                continue;
            end
            if (!in_rsp) begin
                in_rsp = 1;
                hold   = (hold_mode != 0) ? 5 : $urandom_range(0, 2);
                h_rd   = rsp_rdata;
                h_err  = rsp_err;
                chk("rsp_latency", 64'(cyc - exp_q[0].acc_cyc), 64'(exp_q[0].lat));
            end else begin
                chk("rsp_rdata_stable", {32'd0, rsp_rdata}, {32'd0, h_rd});
                chk("rsp_err_stable", {63'd0, rsp_err}, {63'd0, h_err});
            end
            rsp_ready = (hold == 0);
            if (hold > 0) hold--;
            if (rsp_ready) begin
                e = exp_q.pop_front();
                chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
                chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
                chk("strobe_count", 64'(nstb), 64'(e.nstb));
                if (e.nstb == 1 && nstb == 1) begin
                    chk("strobe_addr", {60'd0, s_addr}, {60'd0, e.addr});
                    chk("strobe_is_write", {63'd0, s_wr}, {63'd0, e.wr});
                end
                nstb = 0;
                in_rsp = 0;
            end
        end
    end

    task automatic send(input logic wr, input logic [3:0] a, input logic [31:0] wd, input int d);
        exp_t e;
        int   t;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
        t = 0;
        while (!cmd_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            n_vec++; n_err++;
            $display("FAIL cmd_accept_timeout: actual cmd_ready=0 required 1 within 300 cycles");
            cmd_valid = 1'b0;
            return;
        end
        e = model(wr, a, wd, d);
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        if (e.nstb != 0) dly_q.push_back(d);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() > 0) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: actual %0d responses pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic reset_release();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        dly_q.delete();
`ifdef EXAMPLE_REG_MASTER_UNINIT_CHECK_EN
        model_bm = '0;
`endif
        #1;
        chk("post_reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("post_reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    endtask

    initial begin
        int dtab[8] = '{0, 1, 2, 3, 5, 16, 17, -1};
        logic [31:0] v;
        logic [3:0]  a;
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        for (int i = 0; i < NR; i++) begin
            v = $urandom;
            model_mem[i] = v;
            resp_mem[i]  = v;
        end
        model_mem[4] = 32'd12;
        resp_mem[4]  = 32'd12;
        @(negedge clk);
        chk("reset_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_strobes", {62'd0, bus_rd, bus_wr}, 64'd0);
        chk("reset_bus_addr", {60'd0, bus_addr}, 64'd0);
        reset_release();

        send(1'b1, 4'd2, 32'h0000_0035, 1);
        send(1'b0, 4'd4, 32'h0, 0);
        send(1'b0, 4'd9, 32'h0, 0);
        send(1'b0, 4'd1, 32'h0, -1);
        send(1'b0, 4'd1, 32'h0, 16);
        send(1'b1, 4'd7, 32'h1234_5678, 17);
        send(1'b0, 4'd7, 32'h0, 18);
        send(1'b1, 4'd15, 32'hFFFF_FFFF, 0);
        drain();

        hold_mode = 1;
        send(1'b1, 4'd0, 32'hCAFE_0001, 2);
        send(1'b0, 4'd0, 32'h0, 0);
        send(1'b0, 4'd10, 32'h0, 0);
        drain();
        hold_mode = 0;

        send(1'b0, 4'd5, 32'h0, 0);
        send(1'b1, 4'd5, 32'hA5A5_A5A5, 0);
        send(1'b0, 4'd5, 32'h0, 1);
        send(1'b0, 4'd6, 32'h0, 3);
        drain();

        // Reset landing on the ISSUE cycle must kill the strobe in that same cycle.
        send(1'b0, 4'd3, 32'h0, -1);
        chk("issue_strobe_rd", {63'd0, bus_rd}, 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_issue_strobe_rd", {63'd0, bus_rd}, 64'd0);
        chk("rst_issue_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        reset_release();

        send(1'b0, 4'd3, 32'h0, -1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_wait_strobes", {62'd0, bus_rd, bus_wr}, 64'd0);
        chk("rst_wait_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        reset_release();
        repeat (25) @(negedge clk);

        send(1'b0, 4'd5, 32'h0, 0);
        send(1'b1, 4'd8, 32'h0BAD_F00D, 4);
        send(1'b0, 4'd8, 32'h0, 2);
        drain();

        for (int n = 0; n < 60; n++) begin
            a = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            send(1'($urandom_range(0, 1)), a, $urandom, dtab[$urandom_range(0, 7)]);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/example_reg_master.md
Name: example_reg_master

Overview:
- Bus initiator that drives the example register bank (the 9-register, 32-bit responder) from a command/response stream.
- Accepts single read/write commands via valid/ready and runs one register-bus transaction at a time.
- Waits for the responder's ack with a timeout, then returns read data and an error flag on a response channel.
- Sits between a host command source (debug bridge or sequencer) and the register bank.

Parameters:
- ADDR_WIDTH, 4, width of cmd_addr and bus_addr.
- DATA_WIDTH, 32, register data width.
- NUM_REGS, 9, valid addresses are 0..NUM_REGS-1.
- TIMEOUT_CYCLES, 16, maximum cycles in WAIT_ACK before abort; must be 1..255.
- UNRESET_MASK, 9'b001100000, bit i set means register i has no reset value (regs 5, 6).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  master can accept a command
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  register address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  address out of range, timeout, or uninit read
- bus_addr  out  ADDR_WIDTH  register bus address
- bus_wr  out  1  write strobe
- bus_rd  out  1  read strobe
- bus_wdata  out  DATA_WIDTH  write data
- bus_rdata  in  DATA_WIDTH  read data, valid when bus_ack=1
- bus_ack  in  1  responder completion

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: cmd_ready=0 during reset; all other outputs 0; FSM=IDLE; timeout counter=0.
- FSM states: IDLE, ISSUE, WAIT_ACK, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, capture write/addr/wdata.
  - If addr>=NUM_REGS, go to RESP with err=1 and rdata=0; no bus activity.
  - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - bus_addr and bus_wdata are driven from the captured command.
  - bus_wr or bus_rd=1 (strobe is a single-cycle pulse).
  - Timeout counter cleared; go to WAIT_ACK.
  - bus_ack sampled in the ISSUE cycle counts as completion (zero-wait responder); go straight to RESP.
- WAIT_ACK:
  - Strobes are 0; bus_addr and bus_wdata are held.
  - On bus_ack: capture bus_rdata for reads (0 for writes), err=0, go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES with no ack: err=1, rdata=0, go to RESP.
  - A bus_ack arriving in the same cycle as expiry wins: no error.
  - bus_ack outside ISSUE/WAIT_ACK is ignored.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are stable until rsp_valid&&rsp_ready.
  - On acceptance, return to IDLE. The next command is accepted no earlier than the following cycle.
  - cmd_ready=0 in all states except IDLE.
- Latency:
  - Command accept to rsp_valid = 2 cycles plus ack wait.
  - Minimum is 2 (ack during ISSUE).
  - Out-of-range commands take 1 cycle.
- Reset mid-transaction:
  - Aborts immediately, returns to IDLE, and drops any pending response.
  - Strobes deassert in the reset cycle.

Optional Feature:
- Macro: EXAMPLE_REG_MASTER_UNINIT_CHECK_EN.
- Defined:
  - A NUM_REGS-bit written-bitmap is cleared on reset.
  - A bit is set on a successful (acked) write to that address.
  - A read to address i with UNRESET_MASK[i]=1 and bitmap[i]=0 goes IDLE->RESP with err=1, rdata=0, and no bus strobe.
- Undefined: no bitmap; all in-range reads go to the bus.

Test Plan:
- Write reg2=32'h0000_0035; responder acks 1 cycle after strobe -> single bus_wr pulse with addr=2; rsp_valid 3 cycles after accept; err=0; rdata=0.
- Read reg4; responder acks during ISSUE with bus_rdata=12 -> rsp_valid 2 cycles after accept; rsp_rdata=12; err=0; exactly one bus_rd pulse.
- Read addr 9 -> no bus_rd/bus_wr; rsp_err=1, rdata=0 on the next cycle.
- Read reg1, no ack, TIMEOUT_CYCLES=16 -> rsp_err=1 after 16 WAIT_ACK cycles. Same test with ack on cycle 16 -> err=0 with the data.
- Hold rsp_ready=0 for 5 cycles with cmd_valid high -> rsp stable, cmd_ready=0 throughout. Assert reset during WAIT_ACK -> next cycle rsp_valid=0 and all strobes 0; FSM back in IDLE.
- With EXAMPLE_REG_MASTER_UNINIT_CHECK_EN: read reg5 -> err=1, no strobe. Then write reg5=32'hA5A5_A5A5 and read reg5 -> bus read issued, err=0.
